// File: rtl/stream_demux_1_to_2.sv
// Buffered 1-to-2 stream demux: each word is steered by In_Sel into a per-output FIFO, visible one cycle after acceptance.
// Backpressure: In_Ready drops only while the selected FIFO is full; a stalled consumer never blocks the other output.

module stream_demux_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_en, rd_en;

  // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot early.
  assign full   = (cnt_q == CW'(DEPTH));
  assign rd_vld = (cnt_q != '0);
  assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;
  assign count  = cnt_q;
  assign wr_en  = wr_vld & ~full;
  assign rd_en  = rd_vld & rd_rdy;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

module stream_demux_1_to_2 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Sel,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out0_Data,
  output logic             Out0_Valid,
  input  logic             Out0_Ready,
  output logic [WIDTH-1:0] Out1_Data,
  output logic             Out1_Valid,
  input  logic             Out1_Ready,
  output logic [CW-1:0]    Count0,
  output logic [CW-1:0]    Count1
);

  logic full0, full1;
  logic push0_vld, push1_vld;

  assign In_Ready  = In_Sel ? ~full1 : ~full0;
  assign push0_vld = In_Valid & ~In_Sel;
  assign push1_vld = In_Valid &  In_Sel;

  stream_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .wr_vld (push0_vld),
    .wr_dat (In_Data),
    .rd_rdy (Out0_Ready),
    .rd_vld (Out0_Valid),
    .rd_dat (Out0_Data),
    .full   (full0),
    .count  (Count0)
  );

  stream_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .wr_vld (push1_vld),
    .wr_dat (In_Data),
    .rd_rdy (Out1_Ready),
    .rd_vld (Out1_Valid),
    .rd_dat (Out1_Data),
    .full   (full1),
    .count  (Count1)
  );

endmodule

// File: doc/stream_demux_1_to_2.md
Name: stream_demux_1_to_2

Overview:
Buffered 1-to-2 demultiplexer: accepts 32-bit words from one valid/ready producer and steers each word to one of two valid/ready consumers. Steering is set per word by a select bit. Each output has its own FIFO, so one stalled consumer does not block traffic to the other. Used in the processor datapath wherever one result stream fans out to two sinks, e.g. memory read responses split between the fetch path and the load write-back path.

Parameters:
WIDTH, 32, data word width in bits.
DEPTH, 2, entries per output FIFO; power of two, minimum 2.
CW, $clog2(DEPTH)+1, occupancy count width; derived, not to be overridden.

Ports:
Clk  input  1  system clock, rising edge.
Rst_n  input  1  asynchronous active-low reset.
In_Data  input  WIDTH  word from producer.
In_Sel  input  1  destination: 0 = output 0, 1 = output 1.
In_Valid  input  1  producer offers In_Data/In_Sel.
In_Ready  output  1  block accepts this cycle.
Out0_Data  output  WIDTH  head word of FIFO 0.
Out0_Valid  output  1  FIFO 0 non-empty.
Out0_Ready  input  1  consumer 0 takes head.
Out1_Data  output  WIDTH  head word of FIFO 1.
Out1_Valid  output  1  FIFO 1 non-empty.
Out1_Ready  input  1  consumer 1 takes head.
Count0  output  CW  FIFO 0 occupancy.
Count1  output  CW  FIFO 1 occupancy.

Behaviour:
- Reset (Rst_n low, asynchronous): both FIFOs empty; pointers, counts and storage cleared. Out*_Valid=0, Out*_Data=0, Count*=0. Any words in flight when reset asserts are discarded.
- After reset: In_Ready is driven during reset but is 0 in the first cycle after deassertion only if the selected FIFO is full, which it never is after reset.
- In_Ready = not full(FIFO[In_Sel]). It is combinational from In_Sel and the full flags. It does not depend on same-cycle pops: a full FIFO refuses a push even when its consumer pops in that cycle.
- Push: In_Valid & In_Ready at a rising edge writes In_Data at the tail of FIFO[In_Sel].
- The producer holds In_Data and In_Sel stable while In_Valid=1 and In_Ready=0.
- Pop: OutN_Valid & OutN_Ready at a rising edge advances the FIFO N head.
- Latency: a pushed word appears on OutN_Data with OutN_Valid=1 in the cycle after the accepting edge. There is no combinational in-to-out path.
- OutN_Data = storage[head] when non-empty, forced to 0 when empty.
- Ordering: order is preserved within each output. No ordering exists across outputs.
- Count update per FIFO: push only → +1; pop only → -1; both → unchanged; neither → unchanged.
- Count range is 0..DEPTH. OutN_Valid = (CountN != 0). full = (CountN == DEPTH).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH with no gap or skipped entry.
- Simultaneous push to FIFO 0 and pop from FIFO 1 (or the reverse) are independent.
- A pop on an empty FIFO is impossible by the handshake; Ready with Valid=0 is ignored.
- In_Valid=0 ignores In_Sel and In_Data. In_Sel X while In_Valid=1 is a producer protocol violation: the bench flags it, and the RTL behaviour is unspecified.

Test Plan:
- Reset mid-traffic: push 0xAAAA0001 to out 0, assert Rst_n=0 before pop → Out0_Valid=0, Out0_Data=0, Count0=0 immediately and after release.
- Steering and latency: push 0x00000011 (Sel=0) then 0x00000022 (Sel=1), both Ready=1 → Out0 shows 0x11 one cycle after its push edge, Out1 shows 0x22 one cycle after its push edge; each counts 1→0.
- Full/backpressure: Out0_Ready=0, push 0x1,0x2 to out 0 → Count0=2, In_Ready=0 for Sel=0. Same cycle with Sel=1 → In_Ready=1; push 0x3 to out 1 → Out1_Data=0x3 next cycle.
- Full with pop: FIFO 0 full, Out0_Ready=1, In_Valid=1, Sel=0 → no push that cycle, Count0 2→1. Push of 0x4 occurs next cycle; pop order is 0x1, 0x2, 0x4.
- Wrap-around and simultaneous push/pop: stream 0x100..0x10F to out 0 with Out0_Ready=1 and In_Valid=1 every cycle → one word per cycle, Count0 steady at 1, all 16 words in order, no loss or duplication.
- Random: 2000 cycles of random Valid/Sel/Ready against a scoreboard of two queues → exact data and order match per output, Count equals queue depth each cycle.
